// File: rtl/mem_wb_stage_if.sv
// MEM -> WB boundary bundle: MEM-side instruction slot in, registered WB slot and counter out.
interface mem_wb_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
);
  logic             mem_valid;
  logic [XLEN-1:0]  readData;
  logic [XLEN-1:0]  aluResult;
  logic [XLEN-1:0]  pcPlus4;
  logic [4:0]       rd;
  logic             regWrite;
  logic             memRead;
  logic [1:0]       wbSel;
  logic [2:0]       funct3;
  logic             stall;
  logic             flush;

  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             wb_regWrite;
  logic [XLEN-1:0]  wb_data;
  logic             wb_misaligned;
  logic [CNT_W-1:0] instret;

  modport master (
    output mem_valid, readData, aluResult, pcPlus4, rd, regWrite, memRead,
           wbSel, funct3, stall, flush,
    input  wb_valid, wb_rd, wb_regWrite, wb_data, wb_misaligned, instret
  );

  modport slave (
    input  mem_valid, readData, aluResult, pcPlus4, rd, regWrite, memRead,
           wbSel, funct3, stall, flush,
    output wb_valid, wb_rd, wb_regWrite, wb_data, wb_misaligned, instret
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load extraction, writeback select, stall/flush and retire counting.
module mem_wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic           clk,
  input  logic           reset,
  mem_wb_stage_if.slave  bus
);

  logic             wb_valid_q,      wb_valid_d;
  logic [4:0]       wb_rd_q,         wb_rd_d;
  logic             wb_regWrite_q,   wb_regWrite_d;
  logic [XLEN-1:0]  wb_data_q,       wb_data_d;
  logic             wb_misaligned_q, wb_misaligned_d;
  logic [CNT_W-1:0] instret_q,       instret_d;

  logic [1:0]       off;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic             is_byte;
  logic             is_half;
  logic             is_word;
  logic             misaligned;
  logic [XLEN-1:0]  load_val;
  logic [XLEN-1:0]  sel_val;
  logic             capture;

  // Load extraction and misalignment; funct3[2] selects zero extension for B/H.
  always_comb begin
    off      = bus.aluResult[1:0];
    byte_v   = bus.readData[{off, 3'b000} +: 8];
    half_v   = bus.readData[{off[1], 4'b0000} +: 16];
    is_byte  = (bus.funct3[1:0] == 2'b00);
    is_half  = (bus.funct3[1:0] == 2'b01);
    is_word  = !is_byte && !is_half;
    load_val = bus.readData;
    if (is_byte) begin
      load_val = bus.funct3[2] ? {{(XLEN-8){1'b0}}, byte_v}
                               : {{(XLEN-8){byte_v[7]}}, byte_v};
    end else if (is_half) begin
      load_val = bus.funct3[2] ? {{(XLEN-16){1'b0}}, half_v}
                               : {{(XLEN-16){half_v[15]}}, half_v};
    end
    misaligned = bus.memRead &&
                 ((is_half && off[0]) || (is_word && (off != 2'b00)));
    case (bus.wbSel)
      2'b01:   sel_val = load_val;
      2'b10:   sel_val = bus.pcPlus4;
      default: sel_val = bus.aluResult;
    endcase
  end

  // Next-state: flush beats stall, stall holds, otherwise capture.
  always_comb begin
    wb_valid_d      = wb_valid_q;
    wb_rd_d         = wb_rd_q;
    wb_regWrite_d   = wb_regWrite_q;
    wb_data_d       = wb_data_q;
    wb_misaligned_d = wb_misaligned_q;
    instret_d       = instret_q;
    capture         = !bus.flush && !bus.stall;
    if (bus.flush) begin
      wb_valid_d      = 1'b0;
      wb_rd_d         = 5'd0;
      wb_regWrite_d   = 1'b0;
      wb_data_d       = '0;
      wb_misaligned_d = 1'b0;
    end else if (capture) begin
      wb_valid_d      = bus.mem_valid;
      wb_rd_d         = bus.rd;
      wb_regWrite_d   = bus.mem_valid && bus.regWrite && (bus.rd != 5'd0) && !misaligned;
      wb_data_d       = sel_val;
      wb_misaligned_d = bus.mem_valid && misaligned;
      if (bus.mem_valid && !misaligned) begin
        instret_d = instret_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= 5'd0;
      wb_regWrite_q   <= 1'b0;
      wb_data_q       <= '0;
      wb_misaligned_q <= 1'b0;
      instret_q       <= '0;
    end else begin
      wb_valid_q      <= wb_valid_d;
      wb_rd_q         <= wb_rd_d;
      wb_regWrite_q   <= wb_regWrite_d;
      wb_data_q       <= wb_data_d;
      wb_misaligned_q <= wb_misaligned_d;
      instret_q       <= instret_d;
    end
  end

  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_rd         = wb_rd_q;
  assign bus.wb_regWrite   = wb_regWrite_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.wb_misaligned = wb_misaligned_q;
  assign bus.instret       = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: per-cycle compare against a behavioural model plus directed literal checks.
module tb_mem_wb_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.XLEN(32), .CNT_W(64)) bus ();
  mem_wb_stage_if #(.XLEN(32), .CNT_W(4))  bus4 ();

  mem_wb_stage #(.XLEN(32), .CNT_W(64)) dut  (.clk(clk), .reset(reset), .bus(bus));
  mem_wb_stage #(.XLEN(32), .CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

  logic v4 = 1'b0;
  assign bus4.mem_valid = v4;
  assign bus4.readData  = 32'h0;
  assign bus4.aluResult = 32'h0;
  assign bus4.pcPlus4   = 32'h0;
  assign bus4.rd        = 5'd1;
  assign bus4.regWrite  = 1'b1;
  assign bus4.memRead   = 1'b0;
  assign bus4.wbSel     = 2'b00;
  assign bus4.funct3    = 3'b010;
  assign bus4.stall     = 1'b0;
  assign bus4.flush     = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: what the WB register must hold, from the stage's rules.
  logic        m_valid = 0, m_rw = 0, m_mis = 0;
  logic [4:0]  m_rd = 0;
  logic [31:0] m_data = 0;
  logic [63:0] m_cnt = 0;

  function automatic int unsigned acc_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
    int unsigned sz;
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sz = acc_size(f3);
    if (sz == 1) begin
      sh = word >> ((addr % 4) * 8);
      b  = sh[7:0];
      return (f3 == 3'd4) ? {24'h0, b} : 32'($signed(b));
    end
    if (sz == 2) begin
      sh = word >> ((addr & 32'd2) * 8);
      h  = sh[15:0];
      return (f3 == 3'd5) ? {16'h0, h} : 32'($signed(h));
    end
    return word;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic mis;
    if (reset) begin
      m_valid = 0; m_rw = 0; m_mis = 0; m_rd = 0; m_data = 0; m_cnt = 0;
    end else if (bus.flush) begin
      m_valid = 0; m_rw = 0; m_mis = 0; m_rd = 0; m_data = 0;
    end else if (!bus.stall) begin
      mis     = bus.memRead && ((bus.aluResult % acc_size(bus.funct3)) != 0);
      m_valid = bus.mem_valid;
      m_rw    = bus.mem_valid && bus.regWrite && (bus.rd != 0) && !mis;
      m_mis   = bus.mem_valid && mis;
      m_rd    = bus.rd;
      m_data  = (bus.wbSel == 2'b01) ? model_load(bus.readData, bus.aluResult, bus.funct3) :
                (bus.wbSel == 2'b10) ? bus.pcPlus4 : bus.aluResult;
      if (bus.mem_valid && !mis) m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_valid", 64'(bus.wb_valid),      64'(m_valid));
      chk("cmp_rd",    64'(bus.wb_rd),         64'(m_rd));
      chk("cmp_rw",    64'(bus.wb_regWrite),   64'(m_rw));
      chk("cmp_data",  64'(bus.wb_data),       64'(m_data));
      chk("cmp_mis",   64'(bus.wb_misaligned), 64'(m_mis));
      chk("cmp_cnt",   bus.instret,            m_cnt);
    end
  end

  // Drive one MEM slot at a falling edge, then wait for the next falling edge.
  task automatic issue(input logic v, input logic [31:0] rdat, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [4:0] r, input logic rw,
                       input logic mr, input logic [1:0] sel, input logic [2:0] f3,
                       input logic st, input logic fl);
    bus.mem_valid = v;   bus.readData = rdat; bus.aluResult = alu; bus.pcPlus4 = pc4;
    bus.rd        = r;   bus.regWrite = rw;   bus.memRead   = mr;  bus.wbSel   = sel;
    bus.funct3    = f3;  bus.stall    = st;   bus.flush     = fl;
    @(negedge clk);
  endtask

  localparam logic [31:0] RD = 32'h8081_F2A5;

  initial begin
    issue(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 0, 0);
    @(negedge clk);
    chk("rst_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_cnt",   bus.instret,       64'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    for (int i = 1; i <= 5; i++)
      issue(1, 0, 32'(i), 0, 5'(i), 1, 0, 2'b00, 3'b010, 0, 0);
    chk("pre_rst_cnt",   bus.instret,       64'd5);
    chk("pre_rst_valid", 64'(bus.wb_valid), 64'd1);

    // Asynchronous reset in the middle of a clock low phase.
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.wb_valid),    64'd0);
    chk("arst_rw",    64'(bus.wb_regWrite), 64'd0);
    chk("arst_data",  64'(bus.wb_data),     64'd0);
    chk("arst_rd",    64'(bus.wb_rd),       64'd0);
    chk("arst_cnt",   bus.instret,          64'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(1, 0, 32'h77, 0, 5'd3, 1, 0, 2'b00, 3'b010, 0, 0);
    chk("post_rst_cnt", bus.instret, 64'd1);

    issue(1, RD, 32'h100, 0, 5'd4, 1, 1, 2'b01, 3'b000, 0, 0);
    chk("lb",  64'(bus.wb_data), 64'h0000_0000_FFFF_FFA5);
    chk("lb_rw", 64'(bus.wb_regWrite), 64'd1);
    issue(1, RD, 32'h103, 0, 5'd4, 1, 1, 2'b01, 3'b100, 0, 0);
    chk("lbu", 64'(bus.wb_data), 64'h0000_0080);
    issue(1, RD, 32'h102, 0, 5'd4, 1, 1, 2'b01, 3'b001, 0, 0);
    chk("lh",  64'(bus.wb_data), 64'hFFFF_8081);
    issue(1, RD, 32'h100, 0, 5'd4, 1, 1, 2'b01, 3'b101, 0, 0);
    chk("lhu", 64'(bus.wb_data), 64'h0000_F2A5);
    issue(1, RD, 32'h100, 0, 5'd4, 1, 1, 2'b01, 3'b010, 0, 0);
    chk("lw",  64'(bus.wb_data), 64'h8081_F2A5);
    chk("lw_rw", 64'(bus.wb_regWrite), 64'd1);
    chk("loads_cnt", bus.instret, 64'd6);

    issue(1, RD, 32'h102, 0, 5'd5, 1, 1, 2'b01, 3'b010, 0, 0);
    chk("lw_mis",    64'(bus.wb_misaligned), 64'd1);
    chk("lw_mis_rw", 64'(bus.wb_regWrite),   64'd0);
    issue(1, RD, 32'h101, 0, 5'd5, 1, 1, 2'b01, 3'b001, 0, 0);
    chk("lh_mis",    64'(bus.wb_misaligned), 64'd1);
    chk("mis_cnt",   bus.instret,            64'd6);
    issue(1, RD, 32'h103, 0, 5'd5, 1, 1, 2'b01, 3'b000, 0, 0);
    chk("lb_ok_mis", 64'(bus.wb_misaligned), 64'd0);
    chk("lb_ok_cnt", bus.instret,            64'd7);

    issue(1, 0, 32'h999, 32'h40, 5'd6, 1, 0, 2'b10, 3'b010, 0, 0);
    chk("pc4", 64'(bus.wb_data), 64'h40);
    issue(1, 0, 32'h1234, 32'h40, 5'd6, 1, 0, 2'b00, 3'b010, 0, 0);
    chk("alu", 64'(bus.wb_data), 64'h1234);
    issue(1, 0, 32'h55, 32'h40, 5'd0, 1, 0, 2'b11, 3'b010, 0, 0);
    chk("x0_rw",  64'(bus.wb_regWrite), 64'd0);
    chk("x0_cnt", bus.instret,          64'd10);

    issue(1, 0, 32'hA5A5, 0, 5'd7, 1, 0, 2'b00, 3'b010, 0, 0);
    for (int i = 0; i < 3; i++) begin
      issue(1, RD, 32'(i * 16 + 3), 32'h80, 5'(9 + i), 1, 0, 2'b00, 3'b010, 1, 0);
      chk("stall_data", 64'(bus.wb_data), 64'hA5A5);
      chk("stall_rd",   64'(bus.wb_rd),   64'd7);
      chk("stall_cnt",  bus.instret,      64'd11);
    end
    issue(1, RD, 32'h10, 0, 5'd8, 1, 0, 2'b00, 3'b010, 1, 1);
    chk("flush_valid", 64'(bus.wb_valid), 64'd0);
    chk("flush_data",  64'(bus.wb_data),  64'd0);
    chk("flush_cnt",   bus.instret,       64'd11);

    issue(0, 0, 32'h55, 0, 5'd9, 1, 0, 2'b00, 3'b010, 0, 0);
    chk("bub_rw",   64'(bus.wb_regWrite), 64'd0);
    chk("bub_data", 64'(bus.wb_data),     64'h55);
    chk("bub_rd",   64'(bus.wb_rd),       64'd9);

    // 17 retirements through a 4-bit counter leave it at 1.
    for (int i = 0; i < 17; i++) begin
      v4 = 1'b1;
      @(negedge clk);
    end
    v4 = 1'b0;
    chk("wrap_cnt", 64'(bus4.instret), 64'd1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline boundary between the memory-access stage and register-file writeback.
- Each cycle it takes one instruction slot from MEM: raw 32-bit word from data memory, ALU result, PC+4 and destination/control fields.
- Performs load byte/halfword extraction with sign/zero extension and selects the writeback value.
- Registers the result for the WB stage, handles pipeline stall/flush, flags misaligned loads and counts retired instructions.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 64, width of retired-instruction counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_valid  input  1  MEM slot holds a real instruction.
- readData  input  XLEN  raw aligned word from data memory for the current MEM address.
- aluResult  input  XLEN  ALU result; also the load address.
- pcPlus4  input  XLEN  PC+4 of the MEM instruction.
- rd  input  5  destination register.
- regWrite  input  1  instruction writes rd.
- memRead  input  1  instruction is a load.
- wbSel  input  2  writeback source: 00 = ALU, 01 = load, 10 = PC+4, 11 = reserved (treated as ALU).
- funct3  input  3  load width: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- stall  input  1  hold WB register contents.
- flush  input  1  insert a bubble into WB.
- wb_valid  output  1  WB register holds a real instruction.
- wb_rd  output  5  registered destination.
- wb_regWrite  output  1  register-file write enable.
- wb_data  output  XLEN  writeback value.
- wb_misaligned  output  1  registered misaligned-load flag.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0 immediately; instret = 0. This applies mid-stall and mid-flush. First capture occurs on the first rising edge after reset deasserts.
- Latency: one cycle. MEM inputs sampled at edge N appear on wb_* after edge N.
- Load extraction (combinational, before the register), byte offset = aluResult[1:0]:
  - LB/LBU: byte readData[8*off+7:8*off], sign- or zero-extended.
  - LH/LHU: half selected by aluResult[1], sign- or zero-extended.
  - LW: full word.
  - Any other funct3 with memRead is treated as LW.
- Misaligned: memRead & ((LH/LHU & aluResult[0]) | (LW & aluResult[1:0] != 0)).
  - When set, the captured wb_regWrite = 0 and wb_misaligned = 1.
  - wb_data still captures the extracted value (don't-care for consumers).
- Writeback select:
  - wbSel 01 uses the extracted load value.
  - wbSel 10 uses pcPlus4.
  - wbSel 00/11 use aluResult.
- Register update priority, evaluated per edge:
  1. flush: wb_valid = 0, wb_regWrite = 0, wb_misaligned = 0, wb_rd = 0, wb_data = 0. Flush overrides stall.
  2. stall: every wb_* output holds its value.
  3. Otherwise capture:
     - wb_valid = mem_valid.
     - wb_regWrite = mem_valid & regWrite & (rd != 0) & !misaligned.
     - wb_misaligned = mem_valid & misaligned.
     - wb_rd and wb_data take the new values.
- When mem_valid = 0 on a capture, the result is a bubble: wb_regWrite = 0 and wb_misaligned = 0, while wb_data and wb_rd capture normally.
- rd = 0 never produces wb_regWrite = 1.
- instret:
  - Increments by 1 on each capture edge where mem_valid & !misaligned. Flush and stall edges do not increment.
  - A stalled instruction counts once only.
  - Wraps modulo 2^CNT_W with no saturation.
- No combinational path from any input to any output.

Test Plan:
- Reset mid-stream: assert reset with wb_valid = 1 and instret = 5 → all outputs 0 asynchronously, before the next edge; after release, the first capture yields instret = 1.
- Loads: readData = 0x8081_F2A5. LB at aluResult = 0x100 → wb_data 0xFFFF_FFA5. LBU at 0x103 → 0x0000_0080. LH at 0x102 → 0xFFFF_8081. LHU at 0x100 → 0x0000_F2A5. LW → 0x8081_F2A5. Each has wb_regWrite = 1.
- Misaligned: LW at 0x102 and LH at 0x101 → wb_misaligned = 1, wb_regWrite = 0, instret unchanged. LB at 0x103 → not misaligned.
- Sources and x0: wbSel = 10, pcPlus4 = 0x0000_0040 → wb_data 0x40. wbSel = 00, aluResult = 0x1234 → 0x1234. rd = 0 with regWrite = 1 → wb_regWrite = 0, instret still increments.
- Stall/flush: capture instr A, then stall for 3 cycles while the inputs change → wb_* keep A and instret increments once. Assert stall and flush together → bubble, wb_valid = 0, no increment.
- Wrap: instantiate with CNT_W = 4, retire 17 valid instructions → instret = 1.
